// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory behind a processor load/store port. Handles
//   aligned loads and stores, and the unaligned store-word-left/right
//   instructions as an internal read-modify-write. Protocol misuse raises a
//   sticky error flag.
//
// Handshake: the processor presents a request (ReadEn or WriteEn) and holds
//   every request input constant while Stall is high. Requests are sampled only
//   in IDLE and latched there, so input changes during a stalled operation
//   have no effect. A new request is taken in the first cycle the FSM is back
//   in IDLE.
//
// Ports
//   Clock        : single clock, rising edge
//   Reset        : synchronous, active-high
//   Address[15:0]: byte address; word index [15:2], byte offset [1:0]
//   ReadEn       : load request
//   WriteEn      : store request (wins over ReadEn)
//   WriteL/R     : store-word-left / store-word-right qualifiers
//   WriteData    : store data (rt)
//   ReadData     : registered load data, held between loads
//   Stall        : processor must hold request inputs while high
//   Err          : sticky protocol-error flag, cleared only by Reset
//   dbg_state_o  : current FSM state (IDLE=0, RD_WAIT=1, RMW_RD=2, RMW_WR=3)
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_WAIT   = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Address,
  input  logic        ReadEn,
  input  logic        WriteEn,
  input  logic        WriteL,
  input  logic        WriteR,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Err,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [14:0] DEPTH_L = 15'(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_L  = 3'(READ_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_RD  = 2'd2,
    RMW_WR  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      wait_q, wait_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            swl_q, swl_d;
  logic            rd_zero_q, rd_zero_d;
  logic [31:0]     old_q, old_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            stall_c;

  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [13:0]     req_idx;
  logic [1:0]      req_off;
  logic            req_in_range;
  logic            req_rd_bad;

  // Big-endian byte merge for SWL/SWR. Byte 0 is bits [31:24].
  // SWL at offset b: memory bytes b..3 take rt bytes 0..3-b, i.e. rt shifted
  // right by b bytes under a mask covering bytes b..3.
  // SWR at offset b: memory bytes 0..b take rt bytes 3-b..3, i.e. rt shifted
  // left by 3-b bytes (3-b == ~b on two bits) under the matching mask.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] rt,
                                             input logic [1:0]  off,
                                             input logic        left);
    logic [31:0] mask;
    logic [31:0] shifted;
    if (left) begin
      mask    = 32'hFFFF_FFFF >> {off, 3'b000};
      shifted = rt >> {off, 3'b000};
    end else begin
      mask    = 32'hFFFF_FFFF << {~off, 3'b000};
      shifted = rt << {~off, 3'b000};
    end
    return (old_w & ~mask) | (shifted & mask);
  endfunction

  assign req_idx      = Address[15:2];
  assign req_off      = Address[1:0];
  assign req_in_range = ({1'b0, req_idx} < DEPTH_L);
  assign req_rd_bad   = !req_in_range || (req_off != 2'd0);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    swl_d     = swl_q;
    rd_zero_d = rd_zero_q;
    old_d     = old_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stall_c   = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (WriteEn) begin
          // Store wins; a simultaneous load is dropped and flagged.
          if (ReadEn) err_d = 1'b1;
          if (WriteL && WriteR) begin
            err_d = 1'b1;
          end else if (!req_in_range) begin
            err_d = 1'b1;
          end else if (WriteL || WriteR) begin
            stall_c = 1'b1;
            idx_d   = req_idx[AW-1:0];
            off_d   = req_off;
            wdata_d = WriteData;
            swl_d   = WriteL;
            state_d = RMW_RD;
          end else if (req_off != 2'd0) begin
            err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_widx  = req_idx[AW-1:0];
            mem_wdata = WriteData;
          end
        end else if (ReadEn) begin
          // Bad loads still take the full stall but return zero.
          stall_c = 1'b1;
          if (req_rd_bad) err_d = 1'b1;
          if (WAIT_L == 3'd0) begin
            rdata_d = req_rd_bad ? 32'h0 : mem_q[req_idx[AW-1:0]];
          end else begin
            idx_d     = req_idx[AW-1:0];
            rd_zero_d = req_rd_bad;
            wait_d    = WAIT_L - 3'd1;
            state_d   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        stall_c = 1'b1;
        if (wait_q == 3'd0) begin
          rdata_d = rd_zero_q ? 32'h0 : mem_q[idx_q];
          state_d = IDLE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      RMW_RD: begin
        stall_c = 1'b1;
        old_d   = mem_q[idx_q];
        state_d = RMW_WR;
      end

      RMW_WR: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wdata = merge_word(old_q, wdata_q, off_q, swl_q);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      wait_q    <= 3'd0;
      idx_q     <= '0;
      off_q     <= 2'd0;
      wdata_q   <= 32'h0;
      swl_q     <= 1'b0;
      rd_zero_q <= 1'b0;
      old_q     <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      swl_q     <= swl_d;
      rd_zero_q <= rd_zero_d;
      old_q     <= old_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Array has no reset so its contents survive Reset; a write in the reset
  // cycle is suppressed, which aborts an in-flight read-modify-write.
  always_ff @(posedge Clock) begin
    if (!Reset && mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  // Stall is combinational from the request in IDLE; forced low during Reset.
  assign Stall       = stall_c & ~Reset;
  assign ReadData    = rdata_q;
  assign Err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] Address;
  logic        ReadEn;
  logic        WriteEn;
  logic        WriteL;
  logic        WriteR;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [int];

  typedef struct {
    logic        rd;
    logic        wr;
    logic        wl;
    logic        wrr;
    logic [15:0] addr;
    logic [31:0] data;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[27];

  data_mem_responder #(.DEPTH_WORDS(256), .READ_WAIT(1)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Address    (Address),
    .ReadEn     (ReadEn),
    .WriteEn    (WriteEn),
    .WriteL     (WriteL),
    .WriteR     (WriteR),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .Err        (Err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ReadEn = 1'b0; WriteEn = 1'b0; WriteL = 1'b0; WriteR = 1'b0;
    Address = 16'h0; WriteData = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Presents one request, counts stall cycles sampled at
  // the falling edge, and returns at posedge+1 of the cycle the FSM is back in
  // IDLE so the next request can follow immediately.
  task automatic do_req(input logic rd, input logic wr, input logic wl, input logic wrr,
                        input logic [15:0] a, input logic [31:0] d,
                        input bit scramble, output int stalls);
    int  n;
    bit  done;
    stalls = 0;
    n = 0;
    done = 0;
    ReadEn = rd; WriteEn = wr; WriteL = wl; WriteR = wrr;
    Address = a; WriteData = d;
    while (!done) begin
      @(negedge Clock);
      if (Stall) stalls++;
      @(posedge Clock);
      #1;
      n++;
      if (dbg_state == 2'd0) begin
        done = 1;
      end else if (n > 20) begin
        total++;
        bad++;
        $display("FAIL req_timeout: got state=%0d exp state=0", dbg_state);
        done = 1;
      end else if (scramble) begin
        ReadEn    = 1'($urandom_range(0, 1));
        WriteEn   = 1'($urandom_range(0, 1));
        WriteL    = 1'($urandom_range(0, 1));
        WriteR    = 1'($urandom_range(0, 1));
        Address   = 16'($urandom);
        WriteData = $urandom;
      end
    end
    idle_inputs();
  endtask

  task automatic sw(input logic [15:0] a, input logic [31:0] d);
    int s;
    do_req(1'b0, 1'b1, 1'b0, 1'b0, a, d, 1'b0, s);
  endtask

  task automatic lw_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    int s;
    do_req(1'b1, 1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, s);
    chk({name, "_stall"}, 32'(s), 32'd2);
    chk({name, "_rdata"}, ReadData, exp);
  endtask

  // ---------------- test ----------------
  initial begin
    int s;
    Reset = 1'b0;
    idle_inputs();

    //            rd wr wl wr  addr      data          st rdata          err
    vecs[0]  = '{0, 1, 0, 0, 16'h0010, 32'hDEADBEEF, 0, 32'h00000000, 0};
    vecs[1]  = '{1, 0, 0, 0, 16'h0010, 32'h0,        2, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 1, 0, 0, 16'h0020, 32'h11223344, 0, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 1, 1, 0, 16'h0021, 32'hAABBCCDD, 2, 32'hDEADBEEF, 0};
    vecs[4]  = '{1, 0, 0, 0, 16'h0020, 32'h0,        2, 32'h11AABBCC, 0};
    vecs[5]  = '{0, 1, 0, 0, 16'h0020, 32'h11223344, 0, 32'h11AABBCC, 0};
    vecs[6]  = '{0, 1, 0, 1, 16'h0022, 32'hAABBCCDD, 2, 32'h11AABBCC, 0};
    vecs[7]  = '{1, 0, 0, 0, 16'h0020, 32'h0,        2, 32'hBBCCDD44, 0};
    vecs[8]  = '{0, 1, 0, 0, 16'h0030, 32'h11223344, 0, 32'hBBCCDD44, 0};
    vecs[9]  = '{0, 1, 1, 0, 16'h0030, 32'hCAFEF00D, 2, 32'hBBCCDD44, 0};
    vecs[10] = '{1, 0, 0, 0, 16'h0030, 32'h0,        2, 32'hCAFEF00D, 0};
    vecs[11] = '{0, 1, 0, 0, 16'h0040, 32'h11223344, 0, 32'hCAFEF00D, 0};
    vecs[12] = '{0, 1, 1, 0, 16'h0043, 32'hAABBCCDD, 2, 32'hCAFEF00D, 0};
    vecs[13] = '{1, 0, 0, 0, 16'h0040, 32'h0,        2, 32'h112233AA, 0};
    vecs[14] = '{0, 1, 0, 0, 16'h0050, 32'h11223344, 0, 32'h112233AA, 0};
    vecs[15] = '{0, 1, 0, 1, 16'h0050, 32'hAABBCCDD, 2, 32'h112233AA, 0};
    vecs[16] = '{1, 0, 0, 0, 16'h0050, 32'h0,        2, 32'hDD223344, 0};
    vecs[17] = '{0, 1, 0, 1, 16'h0013, 32'h01020304, 2, 32'hDD223344, 0};
    vecs[18] = '{1, 0, 0, 0, 16'h0010, 32'h0,        2, 32'h01020304, 0};
    vecs[19] = '{0, 1, 1, 0, 16'h0022, 32'hAABBCCDD, 2, 32'h01020304, 0};
    vecs[20] = '{1, 0, 0, 0, 16'h0020, 32'h0,        2, 32'hBBCCAABB, 0};
    vecs[21] = '{0, 1, 0, 1, 16'h0041, 32'h55667788, 2, 32'hBBCCAABB, 0};
    vecs[22] = '{1, 0, 0, 0, 16'h0040, 32'h0,        2, 32'h778833AA, 0};
    vecs[23] = '{0, 1, 0, 0, 16'h03FC, 32'h0F0F0F0F, 0, 32'h778833AA, 0};
    vecs[24] = '{1, 0, 0, 0, 16'h03FC, 32'h0,        2, 32'h0F0F0F0F, 0};
    vecs[25] = '{0, 1, 1, 0, 16'h03FD, 32'h12345678, 2, 32'h0F0F0F0F, 0};
    vecs[26] = '{1, 0, 0, 0, 16'h03FC, 32'h0,        2, 32'h0F123456, 0};

    // Reset values, checked while Reset is still high and after release.
    Reset = 1'b1;
    ReadEn = 1'b1;
    @(posedge Clock);
    #1;
    chk("rst_stall_during", {31'b0, Stall}, 32'd0);
    chk("rst_rdata_during", ReadData, 32'h0);
    idle_inputs();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    chk("rst_rdata", ReadData, 32'h0);

    // Table-driven vectors: plain SW/LW, SWL/SWR at every offset.
    for (int i = 0; i < 27; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].wl, vecs[i].wrr,
             vecs[i].addr, vecs[i].data, 1'b0, s);
      chk($sformatf("vec%0d_stall", i), 32'(s), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, Err}, {31'b0, vecs[i].exp_err});
    end

    // Inputs wiggled during stalls must not disturb the latched operation.
    sw(16'h0080, 32'h11223344);
    do_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0081, 32'hAABBCCDD, 1'b1, s);
    chk("scr_swl_stall", 32'(s), 32'd2);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 32'h0, 1'b1, s);
    chk("scr_lw_stall", 32'(s), 32'd2);
    chk("scr_lw_rdata", ReadData, 32'h11AABBCC);
    chk("scr_err", {31'b0, Err}, 32'd0);

    // ReadEn and WriteEn together: write wins, read dropped, Err sticky.
    do_reset();
    do_req(1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 32'h5, 1'b0, s);
    chk("rw_stall", 32'(s), 32'd0);
    chk("rw_rdata", ReadData, 32'h0);
    chk("rw_err", {31'b0, Err}, 32'd1);
    lw_chk("rw_word4", 16'h0004, 32'h5);
    repeat (3) @(posedge Clock);
    #1;
    chk("rw_err_sticky", {31'b0, Err}, 32'd1);
    do_reset();
    chk("rw_err_cleared", {31'b0, Err}, 32'd0);

    // Word index beyond the array.
    sw(16'h0000, 32'hA5A5A5A5);
    lw_chk("oor_pre", 16'h0000, 32'hA5A5A5A5);
    lw_chk("oor_lw", 16'h0400, 32'h0);
    chk("oor_lw_err", {31'b0, Err}, 32'd1);
    do_reset();
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0400, 32'h00000099, 1'b0, s);
    chk("oor_sw_stall", 32'(s), 32'd0);
    chk("oor_sw_err", {31'b0, Err}, 32'd1);
    lw_chk("oor_sw_noalias", 16'h0000, 32'hA5A5A5A5);

    // Misaligned plain accesses.
    do_reset();
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 32'h77777777, 1'b0, s);
    chk("mis_sw_stall", 32'(s), 32'd0);
    chk("mis_sw_err", {31'b0, Err}, 32'd1);
    lw_chk("mis_sw_ignored", 16'h0000, 32'hA5A5A5A5);
    lw_chk("mis_lw", 16'h0011, 32'h0);

    // WriteL and WriteR together.
    do_reset();
    sw(16'h0060, 32'h11111111);
    do_req(1'b0, 1'b1, 1'b1, 1'b1, 16'h0061, 32'h22222222, 1'b0, s);
    chk("lr_stall", 32'(s), 32'd0);
    chk("lr_err", {31'b0, Err}, 32'd1);
    lw_chk("lr_nowrite", 16'h0060, 32'h11111111);

    // Reset during RMW_RD aborts the store (Err was set above).
    sw(16'h0070, 32'h12345678);
    WriteEn = 1'b1; WriteL = 1'b1; Address = 16'h0071; WriteData = 32'hFFFFFFFF;
    @(posedge Clock);
    #1;
    chk("abort_in_rmw_rd", {30'b0, dbg_state}, 32'd2);
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("abort_state", {30'b0, dbg_state}, 32'd0);
    chk("abort_stall", {31'b0, Stall}, 32'd0);
    chk("abort_err", {31'b0, Err}, 32'd0);
    @(posedge Clock);
    #1;
    lw_chk("abort_word", 16'h0070, 32'h12345678);

    // Reset during RD_WAIT clears ReadData.
    ReadEn = 1'b1; Address = 16'h0070;
    @(posedge Clock);
    #1;
    chk("rdabort_in_wait", {30'b0, dbg_state}, 32'd1);
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rdabort_state", {30'b0, dbg_state}, 32'd0);
    chk("rdabort_rdata", ReadData, 32'h0);

    // Back-to-back alternating SW/LW against a reference model.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      logic [15:0] a;
      logic [31:0] d;
      int          st;
      a = 16'h0100 + 16'(i * 4);
      d = $urandom;
      do_req(1'b0, 1'b1, 1'b0, 1'b0, a, d, 1'b0, st);
      model[i] = d;
      do_req(1'b1, 1'b0, 1'b0, 1'b0, a, 32'h0, 1'b0, st);
      exp_q.push_back(model[i]);
      chk($sformatf("seq%0d_stall", i), 32'(st), 32'd2);
      chk($sformatf("seq%0d_rdata", i), ReadData, exp_q.pop_front());
    end
    chk("seq_err", {31'b0, Err}, 32'd0);
    chk("seq_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
